// File: rtl/scr1_imem_trace_pkg.sv
// Shared definitions for the IMEM fetch tracer: response encodings,
// trace classes, RISC-V shift decode constants and the trace record layout.
package scr1_imem_trace_pkg;

    localparam logic [1:0] RESP_IDLE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ER   = 2'b10;
    localparam logic [1:0] RESP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        CLS_OTHER = 3'd0,
        CLS_SLL   = 3'd1,
        CLS_SRL   = 3'd2,
        CLS_SRA   = 3'd3,
        CLS_SLLI  = 3'd4,
        CLS_SRLI  = 3'd5,
        CLS_SRAI  = 3'd6,
        CLS_RSVD  = 3'd7
    } trace_cls_e;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        trace_cls_e  cls;
    } trace_rec_t;

    // Decode the shift family from opcode/funct3/funct7 (bits [31:25]).
    function automatic trace_cls_e classify_instr(input logic [6:0] op,
                                                  input logic [2:0] f3,
                                                  input logic [6:0] f7);
        trace_cls_e cls;
        cls = CLS_OTHER;
        if (op == OP_REG) begin
            if (f3 == F3_SLL && f7 == F7_ZERO)     cls = CLS_SLL;
            else if (f3 == F3_SR && f7 == F7_ZERO) cls = CLS_SRL;
            else if (f3 == F3_SR && f7 == F7_ALT)  cls = CLS_SRA;
        end else if (op == OP_IMM) begin
            if (f3 == F3_SLL && f7 == F7_ZERO)     cls = CLS_SLLI;
            else if (f3 == F3_SR && f7 == F7_ZERO) cls = CLS_SRLI;
            else if (f3 == F3_SR && f7 == F7_ALT)  cls = CLS_SRAI;
        end
        return cls;
    endfunction

endpackage

// File: rtl/scr1_trace_fifo_sync.sv
// Synchronous FIFO; a push while full is accepted when a pop happens
// in the same cycle. Head data is read straight from the storage registers.
module scr1_trace_fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/scr1_imem_fetch_tracer.sv
// Pairs accepted IMEM fetch addresses with their responses, classifies the
// returned instruction and queues trace records for a valid/ready consumer.
module scr1_imem_fetch_tracer
    import scr1_imem_trace_pkg::*;
#(
    parameter int ADDR_Q_DEPTH = 4,
    parameter int TRACE_DEPTH  = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_req_ack,
    input  logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic [1:0]       imem_resp,
    output logic             trace_vld,
    input  logic             trace_rdy,
    output logic [31:0]      trace_addr,
    output logic [31:0]      trace_instr,
    output logic             trace_err,
    output logic [2:0]       trace_cls,
    output logic [CNT_W-1:0] srl_cnt,
    output logic [CNT_W-1:0] shift_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             err_orphan,
    output logic             err_aq_ovf
);
    logic        req_fire;
    logic        resp_ok;
    logic        resp_er;
    logic        resp_vld;
    logic        aq_push;
    logic        aq_pop;
    logic        aq_full;
    logic        aq_empty;
    logic [31:0] aq_head;
    logic        aq_bypass;
    logic [31:0] pair_addr;

    trace_rec_t  new_rec;
    trace_rec_t  head_rec;
    logic        tf_full;
    logic        tf_empty;
    logic        tf_pop;

    logic        srl_hit;
    logic        shift_hit;
    logic        drop_hit;
    logic        orphan_hit;
    logic        ovf_hit;

    assign req_fire = imem_req & imem_req_ack;
    assign resp_ok  = (imem_resp == RESP_OK);
    assign resp_er  = (imem_resp == RESP_ER);
    assign resp_vld = resp_ok | resp_er;

    // A request arriving with a response into an empty queue is consumed
    // directly as the pair address and never enters the queue.
    assign aq_bypass = resp_vld & aq_empty & req_fire;
    assign aq_push   = req_fire & ~aq_bypass;
    assign aq_pop    = resp_vld & ~aq_empty;

    assign orphan_hit = resp_vld & aq_empty & ~req_fire;
    assign ovf_hit    = req_fire & aq_full & ~aq_pop;

    // Pick the address paired with this cycle's response.
    always_comb begin
        pair_addr = aq_head;
        if (aq_empty) pair_addr = req_fire ? imem_addr : 32'hFFFF_FFFF;
    end

    // Build the record for this cycle's response.
    always_comb begin
        new_rec.addr  = pair_addr;
        new_rec.instr = resp_ok ? imem_rdata : 32'h0;
        new_rec.err   = resp_er;
        new_rec.cls   = resp_ok ? classify_instr(imem_rdata[6:0], imem_rdata[14:12],
                                                 imem_rdata[31:25])
                                : CLS_OTHER;
    end

    scr1_trace_fifo_sync #(.WIDTH(32), .DEPTH(ADDR_Q_DEPTH)) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (aq_push),
        .push_data (imem_addr),
        .pop       (aq_pop),
        .pop_data  (aq_head),
        .full      (aq_full),
        .empty     (aq_empty)
    );

    scr1_trace_fifo_sync #(.WIDTH($bits(trace_rec_t)), .DEPTH(TRACE_DEPTH)) u_trace_q (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_vld),
        .push_data (new_rec),
        .pop       (tf_pop),
        .pop_data  (head_rec),
        .full      (tf_full),
        .empty     (tf_empty)
    );

    assign trace_vld   = ~tf_empty;
    assign tf_pop      = trace_vld & trace_rdy;
    assign trace_addr  = trace_vld ? head_rec.addr  : 32'h0;
    assign trace_instr = trace_vld ? head_rec.instr : 32'h0;
    assign trace_err   = trace_vld ? head_rec.err   : 1'b0;
    assign trace_cls   = trace_vld ? head_rec.cls   : 3'd0;

    assign srl_hit   = resp_ok & ((new_rec.cls == CLS_SRL) | (new_rec.cls == CLS_SRLI));
    assign shift_hit = resp_ok & (new_rec.cls != CLS_OTHER);
    assign drop_hit  = resp_vld & tf_full & ~tf_pop;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            srl_cnt   <= '0;
            shift_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (srl_hit && srl_cnt != '1)     srl_cnt   <= srl_cnt + 1'b1;
            if (shift_hit && shift_cnt != '1) shift_cnt <= shift_cnt + 1'b1;
            if (drop_hit && drop_cnt != '1)   drop_cnt  <= drop_cnt + 1'b1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
            err_aq_ovf <= 1'b0;
        end else begin
            if (orphan_hit) err_orphan <= 1'b1;
            if (ovf_hit)    err_aq_ovf <= 1'b1;
        end
    end

endmodule

// File: doc/scr1_imem_fetch_tracer.md
Name: scr1_imem_fetch_tracer

Overview:
Synthesizable fetch tracer on the core↔IMEM bridge interface; consumes the same request/response traffic the simulation shift-instruction logger inspects.
- Pairs each accepted fetch address with its later response.
- Classifies the returned instruction (shift ops called out explicitly).
- Buffers trace records in a FIFO drained by a valid/ready consumer (TB logger or debug port).
- Keeps sticky error flags and event counters.

Parameters:
ADDR_Q_DEPTH, 4, max outstanding accepted requests awaiting response (power of 2, ≥2)
TRACE_DEPTH, 8, trace FIFO entries (power of 2, ≥2)
CNT_W, 32, width of event counters

Ports:
clk  in  1  core clock
rst  in  1  async reset, active-high
imem_req  in  1  core fetch request
imem_req_ack  in  1  bridge accepts request
imem_addr  in  32  fetch address, valid with imem_req
imem_rdata  in  32  fetched word, valid when imem_resp != IDLE
imem_resp  in  2  00 IDLE, 01 OK, 10 ER
trace_vld  out  1  trace FIFO head valid
trace_rdy  in  1  consumer ready
trace_addr  out  32  head record fetch address
trace_instr  out  32  head record instruction (0 on ER)
trace_err  out  1  head record was an ER response
trace_cls  out  3  head record class
srl_cnt  out  CNT_W  OK responses classed SRL or SRLI
shift_cnt  out  CNT_W  OK responses of any shift class
drop_cnt  out  CNT_W  records lost to a full trace FIFO
err_orphan  out  1  sticky: response seen with empty address queue
err_aq_ovf  out  1  sticky: request accepted with full address queue

Behaviour:
- Reset: all outputs 0; both queues empty; counters 0; sticky flags cleared. Reset mid-operation discards all in-flight state immediately.
- Address queue push: imem_req & imem_req_ack pushes imem_addr.
- Address queue pop: imem_resp ∈ {OK, ER} pops the head. Response cycle uses the head address combinationally.
- Simultaneous push and pop are legal in any state, including full; occupancy is unchanged.
- Push while full without a simultaneous pop: address dropped, err_aq_ovf set.
- Response with empty queue:
  - err_orphan set.
  - Record still produced with trace_addr = 0xFFFF_FFFF.
  - If a push occurs the same cycle, it bypasses to the head and is used as the pair address.
- imem_resp = 2'b11: ignored; no pop, no record.
- Class from imem_rdata, OK responses only:
  - 0 OTHER
  - 1 SLL: op 0110011, f3 001, f7 0000000
  - 2 SRL: op 0110011, f3 101, f7 0000000
  - 3 SRA: op 0110011, f3 101, f7 0100000
  - 4 SLLI: op 0010011, f3 001, [31:25] 0
  - 5 SRLI: op 0010011, f3 101, [31:25] 0
  - 6 SRAI: op 0010011, f3 101, [31:25] 0100000
  - 7 reserved, never produced
  - ER records: cls 0, instr 0, err 1.
- Trace FIFO:
  - Write on any OK/ER response; record visible on trace_vld the cycle after the response (1-cycle latency).
  - Pop on trace_vld & trace_rdy.
  - Full with simultaneous pop: write accepted.
  - Full without pop: record dropped, drop_cnt += 1.
  - Outputs are registered from FIFO head; stable while trace_vld & !trace_rdy.
- Counters:
  - Update in the cycle after the response.
  - All saturate at all-ones; no wrap.
  - srl_cnt and shift_cnt count on classification, regardless of FIFO drop.

Decomposition:
- Package scr1_imem_trace_pkg:
  - imem_resp encoding localparams.
  - trace_cls_e enum.
  - opcode/funct3/funct7 constants.
  - Trace record struct: addr, instr, err, cls.
- One natural sub-module: scr1_trace_fifo_sync, a parameterized width/depth synchronous FIFO with full/empty and simultaneous push/pop-when-full support. Instantiate it twice: address queue (32b) and trace FIFO (record struct).
- Classifier is a package function, not a module.

Test Plan:
- Single SRL fetch:
  - Stimulus: req+ack addr 0x200, next cycle resp OK rdata 0x00C5D533, trace_rdy=1.
  - Response: trace_vld one cycle later, addr 0x200, cls 2, err 0; srl_cnt=1, shift_cnt=1.
- Pipelined mix:
  - Stimulus: 4 back-to-back accepted reqs 0x100..0x10C; responses 0x40C5D533 (SRA), 0x0035D513 (SRLI), ER, 0x00000013 (OTHER).
  - Response: records in order with cls 3, 5, 0 (err 1, instr 0), 0; srl_cnt=1, shift_cnt=2.
- FIFO full:
  - Stimulus: trace_rdy=0, 10 OK responses.
  - Response: 8 records retained; drop_cnt=2.
  - Then trace_rdy=1 with an 11th response in the same cycle as the first pop: accepted, drop_cnt stays 2.
- Address queue:
  - Stimulus: 5 accepted reqs with no responses.
  - Response: err_aq_ovf=1; first 4 addresses paired with subsequent responses in order.
- Orphan:
  - Stimulus: resp OK with empty queue.
  - Response: err_orphan=1; record addr 0xFFFF_FFFF.
  - Repeat with a same-cycle req+ack 0x300: pair addr 0x300, err_orphan unchanged from prior state.
- Reset mid-traffic:
  - Stimulus: assert rst with 3 records queued and 2 requests outstanding.
  - Response: trace_vld=0, all counters and flags 0 immediately.
  - After release, a fresh req/resp traces normally.
